decode_core: RTL and testbench
==============================

Name: decode_core

Overview:
- LZS (Stac) decompressor; the receive-side counterpart of the encode block.
- Consumes the compressed stream as 16-bit words in the same byte order the encoder emits: high byte first, MSB-first bit order.
- Parses literal, match and end-marker tokens, keeps a 2 KB history window, and emits decompressed bytes through a valid/ready interface.
- Sits between the compressed-word FIFO and the byte sink in the decode path and bench.

Parameters:
- HIST_AW, 11, history RAM address width; window is 2^HIST_AW bytes, max offset 2^HIST_AW-1.
- LEN_W, 16, width of the match-length counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- di  input  16  compressed word; di[15] is the first bit of the stream
- die  input  1  di valid
- di_ready  output  1  word accepted on a cycle with die && di_ready
- dout  output  8  decompressed byte
- dout_valid  output  1  dout valid
- dout_ready  input  1  byte accepted on a cycle with dout_valid && dout_ready
- end_pulse  output  1  one-cycle pulse after the end marker and its padding are consumed
- err  output  1  sticky error flag; cleared only by rst

Behaviour:
- Reset values: di_ready=0, dout=0, dout_valid=0, end_pulse=0, err=0. Bit buffer empty, history write pointer 0, written-byte count 0, state S_TOK.
- Bit buffer:
  - 32-bit left-aligned shift register with a 6-bit fill count.
  - di_ready=1 when fill<=16 and err=0.
  - An accepted word is appended below the existing bits (fill+=16).
  - The parser consumes bits from the top; a state stalls until enough bits are present.
- Token parse states:
  - S_TOK: needs 2 bits.
    - First bit 0 -> literal; needs 9 bits total, emits the byte in bits 8..1, back to S_TOK.
    - Prefix 11 -> 7-bit offset (needs 9 bits). Offset 0 is the end marker -> S_PAD. Otherwise -> S_LEN.
    - Prefix 10 -> 11-bit offset (needs 13 bits). Offset 0 -> err.
  - S_LEN (needs up to 4 bits):
    - 00=2, 01=3, 10=4 -> S_COPY.
    - 1100=5, 1101=6, 1110=7 -> S_COPY.
    - 1111 -> S_LENX with len=8.
  - S_LENX: consumes 4-bit nibble n; len+=n. If n==15, stay; else -> S_COPY. len saturates at 2^LEN_W-1; saturation sets err.
  - S_COPY:
    - Reads history[wptr-offset] and emits it; repeats len times.
    - offset > written-byte count (count saturates at window size) -> err, no bytes emitted.
  - S_PAD: discards bits up to the next 16-bit word boundary of the input stream (tracked by a 4-bit consumed-bit counter), pulses end_pulse for 1 cycle, clears the written-byte count, returns to S_TOK for the next stream.
- Output path:
  - Every emitted byte (literal or copy) is written to history at wptr; wptr wraps modulo 2^HIST_AW.
  - dout/dout_valid are registered. While dout_valid && !dout_ready, dout is held stable and parse/copy stall.
  - Throughput is 1 byte/cycle sustained with dout_ready=1, including offset=1 and offset=2 copies. Read-after-write hazards from the synchronous-read RAM are resolved by forwarding the last two emitted bytes.
  - Latency: a literal is on dout within 2 cycles of its final bit becoming available.
- Error handling: on err, the block stops accepting input and stops emitting; any dout_valid already asserted completes its handshake.
- Simultaneous events:
  - A word may be accepted in the same cycle bits are consumed. Fill is computed as fill - used + 16.
  - The end marker and the first token of the next stream may share a word boundary only after the padding is discarded.
- Reset mid-copy: all state is cleared immediately; no further bytes are emitted; history contents are don't-care.

Test Plan:
- Literals: di=0x2090, 0xB000 -> dout 0x41, 0x42, then one end_pulse; err=0.
- Run copy: di=0x30E0, 0x7300 ('a', offset 1, length 5, end) -> six bytes of 0x61, back-to-back, with no bubbles when dout_ready=1.
- Length extension: literal, then offset-1 match coded 1111 1111 0000 -> 1+23 identical bytes. Also an 11-bit offset 2047 match after 2047 literals returns the first literal.
- Backpressure: toggle dout_ready at random (50%) and stall die -> output byte sequence identical to the unstalled run; dout stable while stalled.
- Errors: prefix 10 with offset 0 -> err=1, di_ready=0. A match with offset 5 after 3 bytes -> err, no copy bytes emitted.
- Reset: assert rst during a 23-byte copy -> dout_valid=0 next cycle. Reapplying 0x2090, 0xB000 then decodes correctly.

Source files
------------

// File: rtl/decode_core_if.sv
// Stream interface for the LZS decompressor.
//   di/die/di_ready          : 16-bit compressed words in, MSB-first bit order.
//   dout/dout_valid/dout_ready : decompressed bytes out.
//   end_pulse                : one cycle after an end marker and its padding are consumed.
//   err                      : sticky error flag.
// master = the side that feeds words and sinks bytes; slave = decode_core.
interface decode_core_if;
  logic [15:0] di;
  logic        die;
  logic        di_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        end_pulse;
  logic        err;

  modport master (
    output di, die, dout_ready,
    input  di_ready, dout, dout_valid, end_pulse, err
  );

  modport slave (
    input  di, die, dout_ready,
    output di_ready, dout, dout_valid, end_pulse, err
  );
endinterface

// File: rtl/decode_core.sv
// LZS (Stac) decompressor.
// Takes the compressed stream as 16-bit words (high byte first, MSB-first bits), parses
// literal / match / end-marker tokens, keeps a 2^HIST_AW byte history window and emits the
// decompressed bytes one per cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : decode_core_if.slave (word input, byte output, end_pulse, err)
module decode_core #(
  parameter int unsigned HIST_AW = 11,
  parameter int unsigned LEN_W   = 16
) (
  input logic          clk,
  input logic          rst,
  decode_core_if.slave bus
);

  localparam int unsigned Win = 2 ** HIST_AW;
  // Written-byte count saturates at the window size.
  localparam logic [HIST_AW:0] CntMax = {1'b1, {HIST_AW{1'b0}}};

  typedef enum logic [2:0] {StTok, StLen, StLenx, StCopy, StPad} state_e;

  state_e             state_q, state_d;
  logic [31:0]        buf_q, buf_d;
  logic [5:0]         fill_q, fill_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic               di_ready_q, di_ready_d;
  logic [7:0]         dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               end_pulse_q, end_pulse_d;
  logic               err_q, err_d;
  logic [HIST_AW-1:0] wptr_q, wptr_d;
  logic [HIST_AW-1:0] off_q, off_d;
  logic [HIST_AW:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         last1_q, last1_d;  // most recently emitted byte
  logic [7:0]         last2_q, last2_d;  // byte emitted before that

  logic [7:0]         hist_mem [Win];
  logic [7:0]         rdata_q;
  logic [HIST_AW-1:0] raddr;

  logic               accept;
  logic               can_emit;
  logic               emit;
  logic [7:0]         emit_byte;
  logic [7:0]         copy_byte;
  logic               cnt_clear;
  logic [5:0]         used;
  logic [5:0]         fill_rem;
  logic [31:0]        shifted;
  logic [3:0]         pad;
  logic [LEN_W:0]     len_sum;

  assign accept   = bus.die && di_ready_q;
  assign can_emit = !dout_valid_q || bus.dout_ready;
  // Bits needed to reach the next 16-bit boundary of the input stream.
  assign pad      = 4'd0 - bitcnt_q;
  assign len_sum  = {1'b0, len_q} + (LEN_W + 1)'(buf_q[31:28]);

  // The RAM read lands one cycle late, so the two most recent bytes (which may not be
  // readable yet) come from registers.
  always_comb begin
    if (off_q == HIST_AW'(1)) begin
      copy_byte = last1_q;
    end else if (off_q == HIST_AW'(2)) begin
      copy_byte = last2_q;
    end else begin
      copy_byte = rdata_q;
    end
  end

  // Token parser
  always_comb begin
    state_d     = state_q;
    used        = 6'd0;
    off_d       = off_q;
    len_d       = len_q;
    err_d       = err_q;
    end_pulse_d = 1'b0;
    emit        = 1'b0;
    emit_byte   = 8'h00;
    cnt_clear   = 1'b0;

    if (!err_q) begin
      unique case (state_q)
        StTok: begin
          if (!buf_q[31]) begin
            if (fill_q >= 6'd9 && can_emit) begin
              emit      = 1'b1;
              emit_byte = buf_q[30:23];
              used      = 6'd9;
            end
          end else if (buf_q[30]) begin
            if (fill_q >= 6'd9) begin
              used  = 6'd9;
              off_d = HIST_AW'(buf_q[29:23]);
              state_d = (buf_q[29:23] == 7'd0) ? StPad : StLen;
            end
          end else begin
            if (fill_q >= 6'd13) begin
              used  = 6'd13;
              off_d = HIST_AW'(buf_q[29:19]);
              if (buf_q[29:19] == 11'd0) begin
                err_d = 1'b1;
              end else begin
                state_d = StLen;
              end
            end
          end
        end
        StLen: begin
          if (fill_q >= 6'd2) begin
            if (buf_q[31:30] != 2'b11) begin
              used    = 6'd2;
              len_d   = LEN_W'(buf_q[31:30]) + LEN_W'(2);
              state_d = StCopy;
            end else if (fill_q >= 6'd4) begin
              used = 6'd4;
              if (buf_q[29:28] == 2'b11) begin
                len_d   = LEN_W'(8);
                state_d = StLenx;
              end else begin
                len_d   = LEN_W'(buf_q[29:28]) + LEN_W'(5);
                state_d = StCopy;
              end
            end
          end
        end
        StLenx: begin
          if (fill_q >= 6'd4) begin
            used = 6'd4;
            if (len_sum[LEN_W]) begin
              len_d = '1;
              err_d = 1'b1;
            end else begin
              len_d = len_sum[LEN_W-1:0];
            end
            if (buf_q[31:28] != 4'hf) begin
              state_d = StCopy;
            end
          end
        end
        StCopy: begin
          if ((HIST_AW + 1)'(off_q) > cnt_q) begin
            err_d = 1'b1;
          end else if (can_emit) begin
            emit      = 1'b1;
            emit_byte = copy_byte;
            len_d     = len_q - LEN_W'(1);
            if (len_q == LEN_W'(1)) begin
              state_d = StTok;
            end
          end
        end
        StPad: begin
          if (fill_q >= {2'b00, pad}) begin
            used        = {2'b00, pad};
            end_pulse_d = 1'b1;
            cnt_clear   = 1'b1;
            state_d     = StTok;
          end
        end
        default: state_d = StTok;
      endcase
    end
  end

  // Bit buffer, output register and history bookkeeping
  always_comb begin
    shifted  = buf_q << used;
    fill_rem = fill_q - used;
    buf_d    = shifted;
    fill_d   = fill_rem;
    if (accept) begin
      // New word goes directly below the bits still held.
      buf_d  = shifted | ({bus.di, 16'h0000} >> fill_rem);
      fill_d = fill_rem + 6'd16;
    end
    bitcnt_d   = bitcnt_q + used[3:0];
    di_ready_d = (fill_d <= 6'd16) && !err_d;

    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    wptr_d       = wptr_q;
    last1_d      = last1_q;
    last2_d      = last2_q;
    cnt_d        = cnt_q;
    if (emit) begin
      dout_d       = emit_byte;
      dout_valid_d = 1'b1;
      wptr_d       = wptr_q + HIST_AW'(1);
      last1_d      = emit_byte;
      last2_d      = last1_q;
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + (HIST_AW + 1)'(1);
      end
    end else if (bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end
    if (cnt_clear) begin
      cnt_d = '0;
    end
    // Address of the byte the next copy cycle will emit.
    raddr = wptr_d - off_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StTok;
      buf_q        <= '0;
      fill_q       <= '0;
      bitcnt_q     <= '0;
      di_ready_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      end_pulse_q  <= 1'b0;
      err_q        <= 1'b0;
      wptr_q       <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      last1_q      <= '0;
      last2_q      <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      bitcnt_q     <= bitcnt_d;
      di_ready_q   <= di_ready_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      end_pulse_q  <= end_pulse_d;
      err_q        <= err_d;
      wptr_q       <= wptr_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      last1_q      <= last1_d;
      last2_q      <= last2_d;
    end
  end

  // History RAM: single write port, synchronous read.
  always_ff @(posedge clk) begin
    if (emit) begin
      hist_mem[wptr_q] <= emit_byte;
    end
    rdata_q <= hist_mem[raddr];
  end

  assign bus.di_ready   = di_ready_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.end_pulse  = end_pulse_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_decode_core.sv
// Bench for decode_core: table of directed streams (run with and without random
// backpressure), plus hand-written sequences for the 2047-byte offset and reset mid-copy.
module tb_decode_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_core_if bus ();

  decode_core #(
    .HIST_AW (11),
    .LEN_W   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          nw;
    logic [15:0] w [4];
    int          nb;
    logic [7:0]  b [24];
    int          ends;
    logic        err;
    int          b2b_n;  // trailing bytes that must leave on consecutive cycles
  } vec_t;

  vec_t        vecs [5];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] words [$];
  logic [7:0]  got [$];
  int          got_cyc [$];
  int          ends_seen;
  int          stab_err;
  bit          bq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.die        = 1'b0;
    bus.di         = 16'h0000;
    bus.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst di_ready", 32'(bus.di_ready), 32'd0);
    check("rst dout", 32'(bus.dout), 32'd0);
    check("rst dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst end_pulse", 32'(bus.end_pulse), 32'd0);
    check("rst err", 32'(bus.err), 32'd0);
    rst = 1'b0;
  endtask

  // Drive 'words' and collect bytes for max_cyc cycles (or until stop_after bytes).
  task automatic run_stream(input int max_cyc, input bit rnd, input int stop_after);
    int          wi;
    bit          pv;
    logic [7:0]  pd;
    wi        = 0;
    pv        = 1'b0;
    pd        = 8'h00;
    ends_seen = 0;
    stab_err  = 0;
    got.delete();
    got_cyc.delete();
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (pv && !(bus.dout_valid === 1'b1 && bus.dout === pd)) stab_err++;
      if (bus.end_pulse === 1'b1) ends_seen++;
      bus.die        = (wi < words.size()) && (!rnd || $urandom_range(0, 1) == 1);
      bus.di         = (wi < words.size()) ? words[wi] : 16'h0000;
      bus.dout_ready = !rnd || ($urandom_range(0, 1) == 1);
      if (bus.die && bus.di_ready === 1'b1) wi++;
      if (bus.dout_valid === 1'b1 && bus.dout_ready) begin
        got.push_back(bus.dout);
        got_cyc.push_back(c);
      end
      pv = (bus.dout_valid === 1'b1) && !bus.dout_ready;
      pd = bus.dout;
      if (stop_after > 0 && got.size() >= stop_after) break;
    end
    bus.die = 1'b0;
  endtask

  task automatic put(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endtask

  function automatic logic [7:0] lit(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  task automatic load_vec(input int v);
    words.delete();
    for (int i = 0; i < vecs[v].nw; i++) words.push_back(vecs[v].w[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] act;
    rst = 1'b1;
    bus.die = 1'b0;
    bus.di = 16'h0000;
    bus.dout_ready = 1'b0;

    // Literals 'A','B' then end marker.
    vecs[0].nw = 2; vecs[0].w[0] = 16'h2090; vecs[0].w[1] = 16'hB000;
    vecs[0].nb = 2; vecs[0].b[0] = 8'h41; vecs[0].b[1] = 8'h42;
    vecs[0].ends = 1; vecs[0].err = 1'b0; vecs[0].b2b_n = 0;
    // 'a', offset 1 length 5, end.
    vecs[1].nw = 2; vecs[1].w[0] = 16'h30E0; vecs[1].w[1] = 16'h7300;
    vecs[1].nb = 6; for (int i = 0; i < 6; i++) vecs[1].b[i] = 8'h61;
    vecs[1].ends = 1; vecs[1].err = 1'b0; vecs[1].b2b_n = 5;
    // 'a', offset 1 length 1111 1111 0000 (=23), end.
    vecs[2].nw = 3; vecs[2].w[0] = 16'h30E0; vecs[2].w[1] = 16'h7FC3; vecs[2].w[2] = 16'h0000;
    vecs[2].nb = 24; for (int i = 0; i < 24; i++) vecs[2].b[i] = 8'h61;
    vecs[2].ends = 1; vecs[2].err = 1'b0; vecs[2].b2b_n = 23;
    // Prefix 10 with offset 0.
    vecs[3].nw = 1; vecs[3].w[0] = 16'h8000;
    vecs[3].nb = 0; vecs[3].ends = 0; vecs[3].err = 1'b1; vecs[3].b2b_n = 0;
    // 'a','b','c' then offset 5 length 2.
    vecs[4].nw = 3; vecs[4].w[0] = 16'h3098; vecs[4].w[1] = 16'h8C78; vecs[4].w[2] = 16'h5000;
    vecs[4].nb = 3; vecs[4].b[0] = 8'h61; vecs[4].b[1] = 8'h62; vecs[4].b[2] = 8'h63;
    vecs[4].ends = 0; vecs[4].err = 1'b1; vecs[4].b2b_n = 0;

    for (int pass = 0; pass < 2; pass++) begin
      for (int v = 0; v < 5; v++) begin
        do_reset();
        load_vec(v);
        run_stream(300, pass == 1, 0);
        check($sformatf("p%0d v%0d count", pass, v), got.size(), vecs[v].nb);
        for (int k = 0; k < vecs[v].nb; k++) begin
          act = (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF;
          check($sformatf("p%0d v%0d byte%0d", pass, v, k), act, 32'(vecs[v].b[k]));
        end
        check($sformatf("p%0d v%0d end_pulses", pass, v), ends_seen, vecs[v].ends);
        check($sformatf("p%0d v%0d err", pass, v), 32'(bus.err), 32'(vecs[v].err));
        if (vecs[v].err) begin
          check($sformatf("p%0d v%0d di_ready after err", pass, v), 32'(bus.di_ready), 32'd0);
        end
        if (pass == 0 && vecs[v].b2b_n > 0 && got.size() >= vecs[v].nb) begin
          check($sformatf("v%0d copy back-to-back", v),
                got_cyc[vecs[v].nb-1] - got_cyc[vecs[v].nb-vecs[v].b2b_n], vecs[v].b2b_n - 1);
        end
        if (pass == 1) begin
          check($sformatf("v%0d dout stable under stall", v), stab_err, 0);
        end
      end
    end

    // 2047 literals, then 11-bit offset 2047 length 2, end marker.
    do_reset();
    bq.delete();
    for (int i = 0; i < 2047; i++) put(16'(lit(i)), 9);
    put(16'h0002, 2);
    put(16'd2047, 11);
    put(16'h0000, 2);
    put(16'h0180, 9);
    while (bq.size() % 16 != 0) bq.push_back(1'b0);
    words.delete();
    for (int i = 0; i < bq.size(); i += 16) begin
      logic [15:0] w;
      for (int j = 0; j < 16; j++) w[15-j] = bq[i+j];
      words.push_back(w);
    end
    run_stream(6000, 1'b0, 0);
    check("far count", got.size(), 2049);
    act = (got.size() > 100) ? 32'(got[100]) : 32'hFFFF_FFFF;
    check("far literal 100", act, 32'(lit(100)));
    act = (got.size() > 2047) ? 32'(got[2047]) : 32'hFFFF_FFFF;
    check("far copy byte0", act, 32'(lit(0)));
    act = (got.size() > 2048) ? 32'(got[2048]) : 32'hFFFF_FFFF;
    check("far copy byte1", act, 32'(lit(1)));
    check("far end_pulses", ends_seen, 1);
    check("far err", 32'(bus.err), 32'd0);

    // Reset in the middle of the 23-byte copy.
    do_reset();
    load_vec(2);
    run_stream(200, 1'b0, 6);
    check("midcopy bytes before reset", got.size(), 6);
    rst = 1'b1;
    #1;
    check("midcopy dout_valid at reset", 32'(bus.dout_valid), 32'd0);
    @(negedge clk);
    check("midcopy dout_valid next cycle", 32'(bus.dout_valid), 32'd0);
    do_reset();
    load_vec(0);
    run_stream(100, 1'b0, 0);
    check("post-reset count", got.size(), 2);
    act = (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF;
    check("post-reset byte0", act, 32'h41);
    act = (got.size() > 1) ? 32'(got[1]) : 32'hFFFF_FFFF;
    check("post-reset byte1", act, 32'h42);
    check("post-reset end_pulses", ends_seen, 1);
    check("post-reset err", 32'(bus.err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
